pl_stage_fifo: RTL

Parametrised pipeline-stage buffer for the in-order RISC-V core. It replaces the fixed-width, single-slot inter-stage registers with a DEPTH-entry elastic buffer on a valid/ready handshake. It carries a bundled payload of DATA_W bits and emits a configurable bubble word when empty or after a flush. It also keeps saturating stall and flush event counters for performance monitoring. It sits between any two pipeline stages (IF/ID first); the upstream stage drives in_*, and the downstream stage consumes out_*.

---
 rtl/pl_stage_fifo.sv | 58 +++++
 1 files changed

// File: rtl/pl_stage_fifo.sv
// pl_stage_fifo: DEPTH-entry elastic pipeline-stage buffer with bubble output and saturating stall/flush counters
module pl_stage_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 2,
  parameter logic [DATA_W-1:0] NOP_WORD = {DATA_W{1'b0}},
  parameter int CNT_W = 16,
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic [CNT_W-1:0] CMAX = '1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return p == PTR_W'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  // in_ready looks only at count, so a full buffer never accepts even when being drained
  assign in_ready = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign out_data = out_valid ? mem[rd_ptr] : NOP_WORD;
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt != CMAX) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (out_valid || in_valid) && flush_cnt != CMAX) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
